// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enable/flush sequencing, halt drain and stall/redirect counters for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redir_cnt;
    logic             w_dpend;
    logic             w_lduse;
    logic             w_stall;
    logic             w_redir;

    assign w_dpend   = (mem_dREN | mem_dWEN) & ~dhit;
    assign w_lduse   = ex_dREN & (ex_wsel != 5'd0) &
                       ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
    assign stall_cnt = r_stall_cnt;
    assign redir_cnt = r_redir_cnt;

    // state register; reset drops straight to IDLE so no partial outputs survive
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state and per-stage controls; in RUN the hazard rules are checked in priority order
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halt        = 1'b0;
        w_stall     = 1'b0;
        w_redir     = 1'b0;
        case (r_state)
            IDLE: w_next = RUN;
            RUN: begin
                if (w_dpend) begin
                    w_stall = 1'b1;
                end else if (mem_halt) begin
                    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                    {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                    w_stall = 1'b1;
                    w_next  = DRAIN;
                end else if (mem_redirect) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                    w_redir = 1'b1;
                end else if (w_lduse) begin
                    {idex_en, exmem_en, memwb_en} = 3'b111;
                    idex_flush = 1'b1;
                    w_stall    = 1'b1;
                end else if (!ihit) begin
                    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                    ifid_flush = 1'b1;
                    w_stall    = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                end
            end
            DRAIN: begin
                {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                w_next = HALTED;
            end
            default: halt = 1'b1;
        endcase
    end

    // saturating performance counters, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redir && !(&r_redir_cnt))
                r_redir_cnt <= r_redir_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with directed hazard sequences and random traffic
module tb_pipeline_hazard_ctrl;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 0, dhit = 0, mem_dREN = 0, mem_dWEN = 0, mem_redirect = 0, mem_halt = 0, ex_dREN = 0, id_uses_rt = 0;
    logic [4:0] ex_wsel = 0, id_rs = 0, id_rt = 0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt;
    logic [31:0] stall_cnt, redir_cnt;
    logic pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4, exmem_flush4, halt4;
    logic [3:0] stall_cnt4, redir_cnt4;

    typedef struct {
        logic [7:0] en;
        logic       hlt;
        longint     st;
        longint     rd;
    } exp_t;

    exp_t   q[$];
    int     total = 0, bad = 0;
    int     m_ph = 0;
    longint m_stall = 0, m_redir = 0;
    bit     stim_done = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt), .stall_cnt(stall_cnt),
        .redir_cnt(redir_cnt));

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .exmem_flush(exmem_flush4), .halt(halt4), .stall_cnt(stall_cnt4),
        .redir_cnt(redir_cnt4));

    // which hazard rule applies to the current inputs while running
    function automatic int rule();
        if ((mem_dREN | mem_dWEN) & ~dhit) return 1;
        if (mem_halt) return 2;
        if (mem_redirect) return 3;
        if (ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt))) return 4;
        if (!ihit) return 5;
        return 6;
    endfunction

    // control pattern {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes} per rule
    function automatic logic [7:0] pattern(int r);
        case (r)
            2:       return 8'b01111_111;
            3:       return 8'b11111_111;
            4:       return 8'b00111_010;
            5:       return 8'b01111_100;
            6:       return 8'b11111_000;
            default: return 8'b00000_000;
        endcase
    endfunction

    // one cycle: predict outputs for current inputs, queue them, advance the model and the clock
    task automatic tick();
        exp_t e;
        int   r;
        r     = rule();
        e.hlt = (m_ph == 3);
        e.st  = m_stall;
        e.rd  = m_redir;
        e.en  = 8'h00;
        if (!nRST) begin
            e.hlt = 0; e.st = 0; e.rd = 0;
            m_ph = 0; m_stall = 0; m_redir = 0;
        end else if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            e.en = pattern(r);
            if (!e.en[7]) m_stall++;
            if (r == 3) m_redir++;
            if (r == 2) m_ph = 2;
        end else if (m_ph == 2) begin
            e.en = pattern(2);
            m_ph = 3;
        end
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        nRST = 1; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_redirect = 0; mem_halt = 0;
        ex_dREN = 0; ex_wsel = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    endtask

    task automatic chk(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // monitor: every falling edge, compare whatever the DUTs present against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}, e.en);
                chk("halt", halt, e.hlt);
                chk("stall_cnt", stall_cnt, e.st);
                chk("redir_cnt", redir_cnt, e.rd);
                chk("ctrl4", {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4, exmem_flush4}, e.en);
                chk("stall_cnt4", stall_cnt4, e.st > 15 ? 15 : e.st);
                chk("redir_cnt4", redir_cnt4, e.rd > 15 ? 15 : e.rd);
            end
        end
    end

    initial begin
        @(posedge CLK);
        #1;
        nRST = 0;
        tick();
        clr();
        repeat (4) tick();
        mem_dREN = 1;
        repeat (3) tick();
        dhit = 1;
        tick();
        clr();
        ex_dREN = 1; ex_wsel = 5; id_rs = 5;
        tick();
        ex_wsel = 0; id_rs = 0;
        tick();
        clr();
        id_uses_rt = 1; ex_dREN = 1; ex_wsel = 7; id_rt = 7;
        tick();
        clr();
        ihit = 0;
        tick();
        ex_dREN = 1; ex_wsel = 3; id_rs = 3; mem_redirect = 1;
        tick();
        clr();
        mem_dWEN = 1; mem_redirect = 1;
        repeat (2) tick();
        dhit = 1;
        tick();
        clr();
        ihit = 0;
        repeat (20) tick();
        clr();
        mem_halt = 1;
        tick();
        clr();
        repeat (4) tick();
        nRST = 0;
        tick();
        clr();
        repeat (3) tick();
        ihit = 0;
        tick();
        nRST = 0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            clr();
            ihit         = ($urandom_range(0, 3) != 0);
            dhit         = $urandom_range(0, 1);
            mem_dREN     = ($urandom_range(0, 3) == 0);
            mem_dWEN     = ($urandom_range(0, 5) == 0);
            mem_redirect = ($urandom_range(0, 5) == 0);
            mem_halt     = ($urandom_range(0, 60) == 0);
            ex_dREN      = $urandom_range(0, 1);
            ex_wsel      = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = $urandom_range(0, 1);
            if ((m_ph == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 300) == 0) nRST = 0;
            tick();
        end
        clr();
        stim_done = 1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end
endmodule
